// File: rtl/core_fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage (master) and the I-cache (slave).
interface core_fetch_stage_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              if_ic_req_out;
    logic [ADDR_W-1:0] if_ic_addr_out;
    logic              if_ic_ack_in;
    logic [DATA_W-1:0] if_ic_rdata_in;

    modport master (
        output if_ic_req_out,
        output if_ic_addr_out,
        input  if_ic_ack_in,
        input  if_ic_rdata_in
    );

    modport slave (
        input  if_ic_req_out,
        input  if_ic_addr_out,
        output if_ic_ack_in,
        output if_ic_rdata_in
    );
endinterface

// File: rtl/core_fetch_stage.sv
// Instruction-fetch stage: PC, I-cache request FSM and IF/DEC pipeline register.
// Optional CORE_IF_PERF_CNT_EN adds saturating fetch and stall counters.
module core_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    core_fetch_stage_if.master     ic,
    input  logic                   if_enb_in,
    input  logic                   if_kill_in,
    input  logic                   if_mux_trn_in,
    input  logic [31:0]            if_trgt_addr_in,
    output logic [31:0]            if_dec_instr_out,
    output logic [31:0]            if_dec_pc_out,
    output logic                   if_dec_vld_out,
    output logic                   if_stall_out
`ifdef CORE_IF_PERF_CNT_EN
    ,
    output logic [31:0]            if_fetch_cnt_out,
    output logic [31:0]            if_stall_cnt_out
`endif
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic [XLEN-1:0] dec_instr_q, dec_pc_q;
    logic            dec_vld_q;
    logic            load_c;
    logic [XLEN-1:0] load_data_c;
    logic            req_c;
    logic [XLEN-1:0] addr_c;
    logic            stall_c;

    // Next-state, PC update and IF/DEC load decision.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_data_d = hold_data_q;
        load_c      = 1'b0;
        load_data_c = hold_data_q;
        req_c       = 1'b0;
        addr_c      = pc_q;
        stall_c     = 1'b0;

        case (state_q)
            S_FETCH, S_WAIT: begin
                req_c   = 1'b1;
                stall_c = (state_q == S_WAIT) || !ic.if_ic_ack_in;
                if (ic.if_ic_ack_in) begin
                    state_d = S_FETCH;
                    if (!if_mux_trn_in) begin
                        if (if_enb_in) begin
                            load_c      = 1'b1;
                            load_data_c = ic.if_ic_rdata_in;
                        end else begin
                            hold_data_d = ic.if_ic_rdata_in;
                            state_d     = S_HOLD;
                        end
                    end
                end else if (if_mux_trn_in) begin
                    // Outstanding request keeps its address; its data will be thrown away.
                    drop_addr_d = pc_q;
                    state_d     = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (if_mux_trn_in) begin
                    state_d = S_FETCH;
                end else if (if_enb_in) begin
                    load_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                req_c   = 1'b1;
                addr_c  = drop_addr_q;
                stall_c = 1'b1;
                if (ic.if_ic_ack_in) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (if_mux_trn_in) begin
            pc_d = if_trgt_addr_in & ~XLEN'(3);
        end else if (load_c) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // State, PC and IF/DEC register; kill overrides any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            hold_data_q <= '0;
            dec_instr_q <= NOP_INSTR;
            dec_pc_q    <= '0;
            dec_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_data_q <= hold_data_d;
            if (if_kill_in) begin
                dec_instr_q <= NOP_INSTR;
                dec_vld_q   <= 1'b0;
            end else if (load_c) begin
                dec_instr_q <= load_data_c;
                dec_pc_q    <= pc_q;
                dec_vld_q   <= 1'b1;
            end
        end
    end

    assign ic.if_ic_req_out  = req_c & ~rst;
    assign ic.if_ic_addr_out = addr_c;
    assign if_dec_instr_out  = dec_instr_q;
    assign if_dec_pc_out     = dec_pc_q;
    assign if_dec_vld_out    = dec_vld_q;
    assign if_stall_out      = stall_c;

`ifdef CORE_IF_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load_c && !if_kill_in && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
        end
    end

    assign if_fetch_cnt_out = fetch_cnt_q;
    assign if_stall_cnt_out = stall_cnt_q;
`endif
endmodule

// File: tb/tb_core_fetch_stage.sv
// Bench for core_fetch_stage: directed vector table, corner sequences and randomized run vs. a queue-based model.
module tb_core_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb, kill, trn;
    logic [31:0] trgt;
    logic [31:0] dec_instr, dec_pc;
    logic        dec_vld, stall;
`ifdef CORE_IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    core_fetch_stage_if ic_if ();

    core_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ic               (ic_if),
        .if_enb_in        (enb),
        .if_kill_in       (kill),
        .if_mux_trn_in    (trn),
        .if_trgt_addr_in  (trgt),
        .if_dec_instr_out (dec_instr),
        .if_dec_pc_out    (dec_pc),
        .if_dec_vld_out   (dec_vld),
        .if_stall_out     (stall)
`ifdef CORE_IF_PERF_CNT_EN
        ,
        .if_fetch_cnt_out (fetch_cnt),
        .if_stall_cnt_out (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one-entry hold queue, outstanding/discard flags and the IF/DEC contents.
    logic [31:0] m_pc, m_drop_addr, m_instr, m_dpc, m_fcnt, m_scnt;
    logic        m_out, m_drop, m_vld;
    logic [31:0] m_buf[$];

    task automatic model_check();
        logic        ereq;
        logic [31:0] eaddr;
        if (rst) begin
            chk("req_in_rst", 32'(ic_if.if_ic_req_out), 32'd0);
        end else begin
            ereq  = (m_buf.size() == 0);
            eaddr = m_drop ? m_drop_addr : m_pc;
            chk("m_req", 32'(ic_if.if_ic_req_out), 32'(ereq));
            if (ereq) chk("m_addr", ic_if.if_ic_addr_out, eaddr);
            chk("m_stall", 32'(stall), 32'(ereq && (m_out || !ic_if.if_ic_ack_in)));
            chk("m_instr", dec_instr, m_instr);
            chk("m_dpc", dec_pc, m_dpc);
            chk("m_vld", 32'(dec_vld), 32'(m_vld));
`ifdef CORE_IF_PERF_CNT_EN
            chk("m_fcnt", fetch_cnt, m_fcnt);
            chk("m_scnt", stall_cnt, m_scnt);
`endif
        end
    endtask

    task automatic model_step();
        logic        req, got, dlv;
        logic [31:0] dd, addr_now;
        if (rst) begin
            m_pc = 32'h0; m_drop_addr = 32'h0; m_instr = NOP; m_dpc = 32'h0;
            m_vld = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
            m_buf.delete();
        end else begin
            req      = (m_buf.size() == 0);
            got      = req && ic_if.if_ic_ack_in;
            addr_now = m_drop ? m_drop_addr : m_pc;
            if (req && (m_out || !ic_if.if_ic_ack_in) && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            dlv = 1'b0;
            dd  = 32'h0;
            if (!trn && enb) begin
                if (!req) begin
                    dlv = 1'b1; dd = m_buf[0];
                end else if (got && !m_drop) begin
                    dlv = 1'b1; dd = ic_if.if_ic_rdata_in;
                end
            end
            if (kill) begin
                m_instr = NOP; m_vld = 1'b0;
            end else if (dlv) begin
                m_instr = dd; m_dpc = m_pc; m_vld = 1'b1;
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            end
            if (trn || (!req && enb)) m_buf.delete();
            else if (got && !m_drop && !enb) m_buf.push_back(ic_if.if_ic_rdata_in);
            if (req && !got) begin
                if (trn && !m_drop) m_drop_addr = addr_now;
                m_drop = m_drop || trn;
            end else begin
                m_drop = 1'b0;
            end
            m_out = req && !got;
            if (trn) m_pc = {trgt[31:2], 2'b00};
            else if (dlv) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        enb, kill, trn, ack;
        logic [31:0] trgt, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic [31:0] e_instr, e_pc;
        logic        e_vld;
    } vec_t;

    function automatic vec_t mk(input logic en, kl, tr, ak, input logic [31:0] tg, rd,
                                input logic rq, input logic [31:0] ad, input logic st,
                                input logic [31:0] ins, pc, input logic vl);
        vec_t v;
        v.enb = en; v.kill = kl; v.trn = tr; v.ack = ak; v.trgt = tg; v.rdata = rd;
        v.e_req = rq; v.e_addr = ad; v.e_stall = st; v.e_instr = ins; v.e_pc = pc; v.e_vld = vl;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        // Each row: inputs for one cycle and the outputs expected during that cycle.
        tbl[0]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0000, 1'b1,32'h00, 1'b0, NOP,           32'h00, 1'b0);
        tbl[1]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0001, 1'b1,32'h04, 1'b0, 32'hA000_0000, 32'h00, 1'b1);
        tbl[2]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h08, 1'b1, 32'hA000_0001, 32'h04, 1'b1);
        tbl[3]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h08, 1'b1, 32'hA000_0001, 32'h04, 1'b1);
        tbl[4]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0002, 1'b1,32'h08, 1'b1, 32'hA000_0001, 32'h04, 1'b1);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0003, 1'b1,32'h0C, 1'b0, 32'hA000_0002, 32'h08, 1'b1);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hFFFF_FFFF, 1'b0,32'h0C, 1'b0, 32'hA000_0002, 32'h08, 1'b1);
        tbl[7]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b0,32'h0C, 1'b0, 32'hA000_0002, 32'h08, 1'b1);
        tbl[8]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0004, 1'b1,32'h10, 1'b0, 32'hA000_0003, 32'h0C, 1'b1);
        tbl[9]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h14, 1'b1, 32'hA000_0004, 32'h10, 1'b1);
        tbl[10] = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0005, 1'b1,32'h14, 1'b1, 32'hA000_0004, 32'h10, 1'b1);
        tbl[11] = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0006, 1'b1,32'h18, 1'b0, 32'hA000_0005, 32'h14, 1'b1);
        tbl[12] = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hA000_0007, 1'b1,32'h1C, 1'b0, 32'hA000_0006, 32'h18, 1'b1);
        tbl[13] = mk(1'b1,1'b1,1'b1,1'b0, 32'h103, 32'h0,         1'b1,32'h20, 1'b1, 32'hA000_0007, 32'h1C, 1'b1);
        tbl[14] = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h20, 1'b1, NOP,           32'h1C, 1'b0);
        tbl[15] = mk(1'b1,1'b0,1'b0,1'b1, 32'h0,   32'hBAD0_BAD0, 1'b1,32'h20, 1'b1, NOP,           32'h1C, 1'b0);
        tbl[16] = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h100,1'b1, NOP,           32'h1C, 1'b0);
        tbl[17] = mk(1'b0,1'b1,1'b0,1'b1, 32'h0,   32'hA000_0008, 1'b1,32'h100,1'b1, NOP,           32'h1C, 1'b0);
        tbl[18] = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b0,32'h100,1'b0, NOP,           32'h1C, 1'b0);
        tbl[19] = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b0,32'h100,1'b0, NOP,           32'h1C, 1'b0);
        tbl[20] = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,         1'b1,32'h104,1'b1, 32'hA000_0008, 32'h100,1'b1);

        rst = 1'b1; enb = 1'b1; kill = 1'b0; trn = 1'b0; trgt = 32'h0;
        ic_if.if_ic_ack_in = 1'b0; ic_if.if_ic_rdata_in = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            enb = tbl[i].enb; kill = tbl[i].kill; trn = tbl[i].trn; trgt = tbl[i].trgt;
            ic_if.if_ic_ack_in = tbl[i].ack; ic_if.if_ic_rdata_in = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("t%0d_req", i), 32'(ic_if.if_ic_req_out), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), ic_if.if_ic_addr_out, tbl[i].e_addr);
            chk($sformatf("t%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("t%0d_instr", i), dec_instr, tbl[i].e_instr);
            chk($sformatf("t%0d_dpc", i), dec_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_vld", i), 32'(dec_vld), 32'(tbl[i].e_vld));
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end

        // PC wrap: redirect near the top of the address space while a request is pending.
        enb = 1'b1; kill = 1'b1; trn = 1'b1; trgt = 32'hFFFF_FFFE; ic_if.if_ic_ack_in = 1'b0;
        cyc();
        kill = 1'b0; trn = 1'b0; trgt = 32'h0; ic_if.if_ic_ack_in = 1'b1; ic_if.if_ic_rdata_in = 32'h1111_1111;
        cyc();
        chk("wrap_addr_hi", ic_if.if_ic_addr_out, 32'hFFFF_FFFC);
        ic_if.if_ic_rdata_in = 32'hC0C0_C0C0;
        cyc();
        chk("wrap_addr_lo", ic_if.if_ic_addr_out, 32'h0);
        chk("wrap_dpc", dec_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", dec_instr, 32'hC0C0_C0C0);

        // Reset in the middle of an outstanding request, with the late ack arriving during reset.
        ic_if.if_ic_ack_in = 1'b0;
        cyc();
        rst = 1'b1; ic_if.if_ic_ack_in = 1'b1; ic_if.if_ic_rdata_in = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0; ic_if.if_ic_ack_in = 1'b0;
        cyc();
        chk("rst_instr", dec_instr, NOP);
        chk("rst_vld", 32'(dec_vld), 32'd0);
        chk("rst_addr", ic_if.if_ic_addr_out, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            enb  = ($urandom_range(0, 3) != 0);
            trn  = ($urandom_range(0, 9) == 0);
            trgt = $urandom;
            kill = (trn || !enb) && ($urandom_range(0, 1) == 1);
            ic_if.if_ic_ack_in   = ($urandom_range(0, 2) != 0);
            ic_if.if_ic_rdata_in = $urandom;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/core_fetch_stage.md
Name: core_fetch_stage

Overview:
- Instruction-fetch stage: holds the PC, issues requests to the instruction cache, and drives the IF/DEC pipeline register.
- Consumes the hazard controller's IF/DEC enable, IF/DEC kill and next-PC select (PC+4 vs redirect target).
- Produces the instruction/PC pair for decode and a fetch-stall indication back to hazard control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/DEC on kill or reset (addi x0,x0,0).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- if_enb_in  in  1  IF/DEC register enable from hazard ctrl; 0 = hold
- if_kill_in  in  1  IF/DEC kill from hazard ctrl; 1 = load NOP
- if_mux_trn_in  in  1  next-PC select; 0 = PC+4, 1 = redirect to if_trgt_addr_in
- if_trgt_addr_in  in  32  branch/jump target from EXE
- if_ic_req_out  out  1  I-cache request valid
- if_ic_addr_out  out  32  I-cache request address (word aligned)
- if_ic_ack_in  in  1  I-cache ack; data valid this cycle
- if_ic_rdata_in  in  32  I-cache read data
- if_dec_instr_out  out  32  IF/DEC instruction
- if_dec_pc_out  out  32  IF/DEC PC of that instruction
- if_dec_vld_out  out  1  IF/DEC contents are a real instruction
- if_stall_out  out  1  fetch cannot supply an instruction this cycle

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, hold buffer empty, instr=NOP_INSTR, dec_pc=0, vld=0. During the rst-high cycle if_ic_req_out=0.
- FSM states and transitions:
  - FETCH: req=1, addr=pc. ack & enb: load IF/DEC {rdata, pc, vld=1}, pc<=pc+4, stay. ack & !enb: store rdata/pc in hold buffer, go HOLD. !ack: go WAIT.
  - WAIT: req=1, addr stable at pc until ack. On ack, same handling as FETCH; then return to FETCH or go to HOLD.
  - HOLD: req=0. When enb=1, load IF/DEC from buffer, pc<=pc+4, go FETCH.
  - DROP: req=1 at the stale address until ack. Data is discarded. Then go FETCH at the already-updated pc.
- Redirect (if_mux_trn_in=1 at edge):
  - pc<=if_trgt_addr_in with bits[1:0] forced 0.
  - Taking effect in FETCH/WAIT with no ack that cycle: go DROP. The address is never changed while a request is unacknowledged.
  - With ack that cycle: the data is discarded and the state goes FETCH.
  - In HOLD: the buffer is discarded and the state goes FETCH.
  - Redirect has priority over PC+4 advance.
- Kill (if_kill_in=1): IF/DEC loads {NOP_INSTR, pc_out unchanged, vld=0} regardless of enb. Kill has priority over enb and over load.
- enb=0 and no kill: IF/DEC holds all fields.
- if_stall_out=1 when state is WAIT or DROP, or state is FETCH with ack=0. It is 0 in HOLD (instruction available, downstream stalled).
- PC arithmetic is 32-bit, wraps 32'hFFFF_FFFC -> 0, no flag.
- rst asserted mid-request: returns to reset state next edge. A subsequent ack belonging to the aborted request while req=0 is ignored.
- An ack in HOLD (req=0) is ignored.

Optional Feature:
- CORE_IF_PERF_CNT_EN defined: adds outputs if_fetch_cnt_out[31:0] and if_stall_cnt_out[31:0].
  - if_fetch_cnt_out counts IF/DEC loads with vld=1.
  - if_stall_cnt_out counts cycles with if_stall_out=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, ack every cycle, enb=1 -> addrs 0,4,8 on consecutive cycles; dec_pc follows one cycle later; vld=1.
- Ack delayed 3 cycles on addr 0x8 -> addr held at 0x8, if_stall_out=1 for 3 cycles, then dec_instr=rdata, dec_pc=0x8.
- Ack with enb=0 for 2 cycles -> HOLD, req=0, IF/DEC unchanged; on enb=1, dec_instr=buffered data, next req addr=pc+4.
- Redirect to 0x103 while request to 0x20 is pending (ack 2 cycles later) -> addr stays 0x20 until ack, data dropped, vld stays 0, next req addr=0x100.
- kill=1 with enb=0 and valid ack -> dec_instr=0x13, vld=0; with CORE_IF_PERF_CNT_EN defined, fetch counter unchanged.
